id_ex_stage_reg: RTL

- Pipeline register between the instruction-decode stage (control unit plus register file) and the execute stage of the 5-stage ARM core.
- Captures every decoded control bit, operand value and immediate field on each clock.
- Supports freeze (hazard stall), which holds contents, and flush (taken branch), which inserts a bubble.
- Tracks a valid bit so that downstream stages and the hazard unit can ignore bubbles.

---
 rtl/id_ex_stage_reg.sv | 110 +++++++++++
 1 files changed

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register for the 5-stage ARM core.
// Captures decoded controls, operands and immediates each rising edge.
// Priority on every edge: rst (async, active-low) > flush > freeze > load.
// flush inserts an all-zero bubble (valid=0). freeze holds every field,
// including valid. Controls and data share one register group.
// Optional build macro: ID_EX_FORWARDING_EN adds the forwarding-unit fields
// src1/src2 and the two_src flag.
// There is no handshake here. valid is a plain qualifier: 1 marks a real
// instruction and 0 marks a bubble that downstream logic must ignore.
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CMD_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [CMD_W-1:0]  exe_cmd_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              wb_en_in,
  input  logic              b_in,
  input  logic              s_in,
  input  logic [DATA_W-1:0] val_rn_in,
  input  logic [DATA_W-1:0] val_rm_in,
  input  logic              imm_in,
  input  logic [11:0]       shift_operand_in,
  input  logic [23:0]       signed_imm24_in,
  input  logic [3:0]        dest_in,
  input  logic              carry_in,
`ifdef ID_EX_FORWARDING_EN
  input  logic [3:0]        src1_in,
  input  logic [3:0]        src2_in,
  output logic [3:0]        src1,
  output logic [3:0]        src2,
  output logic              two_src,
`endif
  output logic [DATA_W-1:0] pc,
  output logic [CMD_W-1:0]  exe_cmd,
  output logic              mem_read,
  output logic              mem_write,
  output logic              wb_en,
  output logic              b,
  output logic              s,
  output logic [DATA_W-1:0] val_rn,
  output logic [DATA_W-1:0] val_rm,
  output logic              imm,
  output logic [11:0]       shift_operand,
  output logic [23:0]       signed_imm24,
  output logic [3:0]        dest,
  output logic              carry,
  output logic              valid
);

  // Main register group: reset/flush clear everything, freeze holds, else load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || flush) begin
      pc            <= '0;
      exe_cmd       <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      wb_en         <= 1'b0;
      b             <= 1'b0;
      s             <= 1'b0;
      val_rn        <= '0;
      val_rm        <= '0;
      imm           <= 1'b0;
      shift_operand <= '0;
      signed_imm24  <= '0;
      dest          <= '0;
      carry         <= 1'b0;
      valid         <= 1'b0;
    end else if (!freeze) begin
      pc            <= pc_in;
      exe_cmd       <= exe_cmd_in;
      mem_read      <= mem_read_in;
      mem_write     <= mem_write_in;
      wb_en         <= wb_en_in;
      b             <= b_in;
      s             <= s_in;
      val_rn        <= val_rn_in;
      val_rm        <= val_rm_in;
      imm           <= imm_in;
      shift_operand <= shift_operand_in;
      signed_imm24  <= signed_imm24_in;
      dest          <= dest_in;
      carry         <= carry_in;
      valid         <= 1'b1;
    end
  end

`ifdef ID_EX_FORWARDING_EN
  // Forwarding fields follow the same clear/hold/load rules as the main group.
  // two_src marks instructions that read Rm as a register or are stores
  // (a store reads its data register through the second source port).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || flush) begin
      src1    <= '0;
      src2    <= '0;
      two_src <= 1'b0;
    end else if (!freeze) begin
      src1    <= src1_in;
      src2    <= src2_in;
      two_src <= (!imm_in && !mem_write_in) || mem_write_in;
    end
  end
`endif

endmodule
